// File: rtl/nic2noc_vc_scheduler_if.sv
// Link-side bundle between the output VC FIFOs and the VC scheduler.
// The master drives requests and returned credits; the slave (scheduler) drives grants and credit state.
interface nic2noc_vc_scheduler_if #(
  parameter int N_TOT_OF_VC   = 6,
  parameter int N_BITS_CREDIT = 3
);
  localparam int ID_W = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;

  logic [N_TOT_OF_VC-1:0]               req_i;
  logic [N_TOT_OF_VC-1:0]               credit_signal_i;
  logic [N_TOT_OF_VC-1:0]               grant_o;
  logic                                 grant_valid_o;
  logic [ID_W-1:0]                      grant_id_o;
  logic [N_TOT_OF_VC*N_BITS_CREDIT-1:0] credit_count_o;
  logic [N_TOT_OF_VC-1:0]               credit_avail_o;
  logic                                 credit_err_o;

  modport master (
    output req_i, credit_signal_i,
    input  grant_o, grant_valid_o, grant_id_o, credit_count_o, credit_avail_o, credit_err_o
  );

  modport slave (
    input  req_i, credit_signal_i,
    output grant_o, grant_valid_o, grant_id_o, credit_count_o, credit_avail_o, credit_err_o
  );
endinterface

// File: rtl/nic2noc_vc_scheduler.sv
// Per-VC downstream credit counters plus a zero-latency round-robin grant of the single NoC link.
// A VC is eligible when it requests and still holds credit; the scan starts at rr_ptr.
module nic2noc_vc_scheduler #(
  parameter int N_TOT_OF_VC   = 6,
  parameter int N_CREDITS     = 4,
  parameter int N_BITS_CREDIT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  nic2noc_vc_scheduler_if.slave        bus
);
  localparam int ID_W = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;
  localparam logic [N_BITS_CREDIT-1:0] CRED_FULL = N_BITS_CREDIT'(N_CREDITS);

  logic [N_TOT_OF_VC-1:0][N_BITS_CREDIT-1:0] credit;
  logic [ID_W-1:0]                           rr_ptr;
  logic                                      err;

  logic [N_TOT_OF_VC-1:0] eligible;
  logic [N_TOT_OF_VC-1:0] grant;
  logic [N_TOT_OF_VC-1:0] ovf;
  logic [ID_W-1:0]        winner;
  logic                   found;
  int                     idx;

  // Simultaneous grant and return cancel out, even on a full counter.
  function automatic logic [N_BITS_CREDIT-1:0] next_credit(
    input logic [N_BITS_CREDIT-1:0] cur,
    input logic                     inc,
    input logic                     dec
  );
    logic [N_BITS_CREDIT-1:0] nxt;
    nxt = cur;
    if (dec && !inc)
      nxt = cur - N_BITS_CREDIT'(1);
    else if (inc && !dec && cur != CRED_FULL)
      nxt = cur + N_BITS_CREDIT'(1);
    return nxt;
  endfunction

  // Combinational arbitration from current requests and registered credit/pointer
  always_comb begin
    eligible = '0;
    grant    = '0;
    ovf      = '0;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int v = 0; v < N_TOT_OF_VC; v++)
      eligible[v] = bus.req_i[v] & (credit[v] != '0);
    for (int k = 0; k < N_TOT_OF_VC; k++) begin
      idx = (int'(rr_ptr) + k) % N_TOT_OF_VC;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    // Grants are suppressed while reset is held, independent of the clock.
    if (!rst) begin
      found  = 1'b0;
      winner = '0;
    end
    if (found)
      grant[winner] = 1'b1;
    for (int v = 0; v < N_TOT_OF_VC; v++)
      ovf[v] = bus.credit_signal_i[v] & ~grant[v] & (credit[v] == CRED_FULL);
  end

  // Registered state update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_TOT_OF_VC; v++)
        credit[v] <= CRED_FULL;
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (found)
        rr_ptr <= (int'(winner) == N_TOT_OF_VC - 1) ? '0 : winner + ID_W'(1);
      for (int v = 0; v < N_TOT_OF_VC; v++)
        credit[v] <= next_credit(credit[v], bus.credit_signal_i[v], grant[v]);
      if (|ovf)
        err <= 1'b1;
    end
  end

  always_comb begin
    bus.grant_o        = grant;
    bus.grant_valid_o  = |grant;
    bus.grant_id_o     = winner;
    bus.credit_count_o = credit;
    bus.credit_err_o   = err;
    for (int v = 0; v < N_TOT_OF_VC; v++)
      bus.credit_avail_o[v] = (credit[v] != '0);
  end
endmodule

// File: tb/tb_nic2noc_vc_scheduler.sv
// Bench for nic2noc_vc_scheduler: directed scenarios then random traffic, predicted by a
// credit/priority-list model and checked by an independent negedge monitor through a queue.
module tb_nic2noc_vc_scheduler;
  localparam int N    = 6;
  localparam int NCR  = 4;
  localparam int NB   = 3;
  localparam int ID_W = 3;

  typedef struct packed {
    logic [N-1:0]    grant;
    logic            gv;
    logic [ID_W-1:0] id;
    logic [N*NB-1:0] cnt;
    logic [N-1:0]    avail;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  nic2noc_vc_scheduler_if #(.N_TOT_OF_VC(N), .N_BITS_CREDIT(NB)) bus ();

  nic2noc_vc_scheduler #(.N_TOT_OF_VC(N), .N_CREDITS(NCR), .N_BITS_CREDIT(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: credits left per VC, VC that currently has top priority, overflow flag.
  int m_cred[N];
  int m_top;
  bit m_err;

  function automatic void model_reset();
    for (int v = 0; v < N; v++) m_cred[v] = NCR;
    m_top = 0;
    m_err = 1'b0;
  endfunction

  // Priority list starts at m_top and wraps; first requester with credit wins.
  function automatic int pick(input bit rv, input logic [N-1:0] rq);
    int order[$];
    if (!rv) return -1;
    for (int k = m_top; k < N; k++) order.push_back(k);
    for (int k = 0; k < m_top; k++) order.push_back(k);
    foreach (order[i])
      if (rq[order[i]] && m_cred[order[i]] > 0) return order[i];
    return -1;
  endfunction

  function automatic exp_t expect_of(input int w);
    exp_t e;
    e = '0;
    if (w >= 0) begin
      e.grant[w] = 1'b1;
      e.gv       = 1'b1;
      e.id       = ID_W'(w);
    end
    for (int v = 0; v < N; v++) begin
      e.cnt[v*NB +: NB] = NB'(m_cred[v]);
      e.avail[v]        = (m_cred[v] != 0);
    end
    e.err = m_err;
    return e;
  endfunction

  function automatic void model_advance(input int w, input logic [N-1:0] cr);
    if (w >= 0) m_top = (w + 1) % N;
    for (int v = 0; v < N; v++) begin
      if (cr[v] && w != v) begin
        if (m_cred[v] == NCR) m_err = 1'b1;
        else m_cred[v] = m_cred[v] + 1;
      end else if (!cr[v] && w == v) begin
        m_cred[v] = m_cred[v] - 1;
      end
    end
  endfunction

  task automatic step(input bit rv, input logic [N-1:0] rq, input logic [N-1:0] cr_in, input bit echo);
    int           w;
    logic [N-1:0] cr;
    @(posedge clk);
    #1;
    if (!rv) model_reset();
    w  = pick(rv, rq);
    cr = cr_in;
    if (echo) cr = (w >= 0) ? N'(1 << w) : '0;
    rst                 = rv;
    bus.req_i           = rq;
    bus.credit_signal_i = cr;
    sb_q.push_back(expect_of(w));
    if (rv) model_advance(w, cr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle presents outputs; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("grant",        32'(bus.grant_o),        32'(e.grant));
      chk("grant_valid",  32'(bus.grant_valid_o),  32'(e.gv));
      chk("grant_id",     32'(bus.grant_id_o),     32'(e.id));
      chk("credit_count", 32'(bus.credit_count_o), 32'(e.cnt));
      chk("credit_avail", 32'(bus.credit_avail_o), 32'(e.avail));
      chk("credit_err",   32'(bus.credit_err_o),   32'(e.err));
    end
  end

  initial begin
    bus.req_i           = '0;
    bus.credit_signal_i = '0;
    model_reset();

    step(1'b0, 6'b000000, 6'b000000, 1'b0);
    step(1'b0, 6'b111111, 6'b000000, 1'b0);

    // Single requester drains VC0, then one returned credit buys one more grant.
    for (int i = 0; i < 5; i++) step(1'b1, 6'b000001, 6'b000000, 1'b0);
    step(1'b1, 6'b000001, 6'b000001, 1'b0);
    step(1'b1, 6'b000001, 6'b000000, 1'b0);
    step(1'b1, 6'b000001, 6'b000000, 1'b0);

    // Two requesters with credits echoed back immediately.
    for (int i = 0; i < 6; i++) step(1'b1, 6'b001010, 6'b000000, 1'b1);

    // Wrap from VC5 to VC0.
    step(1'b1, 6'b010000, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'b100001, 6'b000000, 1'b0);

    // Same-cycle grant and return on VC2 at partial and full credit.
    step(1'b1, 6'b000100, 6'b000000, 1'b0);
    step(1'b1, 6'b000100, 6'b000000, 1'b0);
    step(1'b1, 6'b000100, 6'b000100, 1'b0);
    step(1'b1, 6'b000000, 6'b000100, 1'b0);
    step(1'b1, 6'b000000, 6'b000100, 1'b0);
    step(1'b1, 6'b000100, 6'b000100, 1'b0);
    step(1'b1, 6'b000000, 6'b000000, 1'b0);

    // Overflow on a full counter sets the sticky flag.
    step(1'b1, 6'b000000, 6'b001000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'b000000, 6'b000000, 1'b0);

    // Drain VC1, reset between clock edges, then restart from VC0.
    for (int i = 0; i < 5; i++) step(1'b1, 6'b000010, 6'b000000, 1'b0);
    step(1'b0, 6'b111111, 6'b000000, 1'b0);
    step(1'b1, 6'b111111, 6'b000000, 1'b0);
    step(1'b1, 6'b111111, 6'b000000, 1'b0);

    // Random traffic with sparse credit returns and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rq;
      logic [N-1:0] cr;
      bit           rv;
      rq = N'($urandom);
      cr = N'($urandom) & N'($urandom) & N'($urandom);
      rv = ($urandom_range(0, 79) != 0);
      step(rv, rq, cr, 1'b0);
    end
    step(1'b1, 6'b000000, 6'b000000, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
